// File: rtl/serial_pkg.sv
// Shared encodings for the bit-serial subtractor: FSM state codes and counter sizing.
package serial_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bit counter must reach WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Operand/result bundle of serial_sub; o_ZERO exists only with SERIAL_SUB_ZFLAG_EN.
interface serial_sub_if #(parameter int WIDTH = 16);
  logic             i_CEN;
  logic             i_START;
  logic [WIDTH-1:0] i_A;
  logic [WIDTH-1:0] i_B;
  logic             i_BIN;
  logic             o_BUSY;
  logic             o_DONE;
  logic             o_D;
  logic             o_D_VALID;
  logic [WIDTH-1:0] o_Q;
  logic             o_BOUT;
`ifdef SERIAL_SUB_ZFLAG_EN
  logic             o_ZERO;
`endif

  modport slave (
    input  i_CEN, i_START, i_A, i_B, i_BIN,
`ifdef SERIAL_SUB_ZFLAG_EN
    output o_ZERO,
`endif
    output o_BUSY, o_DONE, o_D, o_D_VALID, o_Q, o_BOUT
  );

  modport master (
    output i_CEN, i_START, i_A, i_B, i_BIN,
`ifdef SERIAL_SUB_ZFLAG_EN
    input  o_ZERO,
`endif
    input  o_BUSY, o_DONE, o_D, o_D_VALID, o_Q, o_BOUT
  );
endinterface

// File: rtl/fs_cell.sv
// Combinational one-bit full subtractor: D = A - B - BIN, BOUT set when the bit underflows.
// Zero latency, no flow control.
module fs_cell (
  input  logic i_A,
  input  logic i_B,
  input  logic i_BIN,
  output logic o_D,
  output logic o_BOUT
);
  assign o_D    = i_A ^ i_B ^ i_BIN;
  assign o_BOUT = (~i_A & i_B) | (~(i_A ^ i_B) & i_BIN);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial LSB-first subtractor Q = A - B - BIN; optional zero flag under SERIAL_SUB_ZFLAG_EN.
// Latency: WIDTH enabled edges after the start edge; i_CEN=0 freezes everything, start ignored while busy.
module serial_sub
  import serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         i_EMUCLK,
  input  logic         i_RST,
  serial_sub_if.slave  bus
);
  localparam int CW = cnt_width(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] q;
  logic             borrow;
  logic             borrow_nxt;
  logic             bout;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             load;
  logic             shift_en;
  logic             last_bit;
`ifdef SERIAL_SUB_ZFLAG_EN
  logic             acc;
  logic             zero;
`endif

  fs_cell u_fs (
    .i_A    (sh_a[0]),
    .i_B    (sh_b[0]),
    .i_BIN  (borrow),
    .o_D    (d),
    .o_BOUT (borrow_nxt)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign shift_en = (state == SHIFT) && bus.i_CEN;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_CEN && bus.i_START) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.i_CEN && last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.i_CEN) begin
          // A start held in DONE reloads directly, skipping IDLE.
          load      = bus.i_START;
          state_nxt = bus.i_START ? SHIFT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      q      <= '0;
      borrow <= 1'b0;
      bout   <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_SUB_ZFLAG_EN
      acc    <= 1'b0;
      zero   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (load) begin
        sh_a   <= bus.i_A;
        sh_b   <= bus.i_B;
        borrow <= bus.i_BIN;
        cnt    <= '0;
        q      <= '0;
        bout   <= 1'b0;
`ifdef SERIAL_SUB_ZFLAG_EN
        acc    <= 1'b0;
        zero   <= 1'b0;
`endif
      end else if (shift_en) begin
        sh_a   <= sh_a >> 1;
        sh_b   <= sh_b >> 1;
        q      <= {d, q[WIDTH-1:1]};
        borrow <= borrow_nxt;
        cnt    <= cnt + CW'(1);
        // Result flags are latched on the final bit so they outlive DONE.
        if (last_bit) begin
          bout <= borrow_nxt;
        end
`ifdef SERIAL_SUB_ZFLAG_EN
        acc <= acc | d;
        if (last_bit) begin
          zero <= ~(acc | d);
        end
`endif
      end
    end
  end

  assign bus.o_BUSY    = (state == SHIFT);
  assign bus.o_D_VALID = (state == SHIFT);
  assign bus.o_DONE    = (state == DONE);
  assign bus.o_D       = d;
  assign bus.o_Q       = q;
  assign bus.o_BOUT    = bout;
`ifdef SERIAL_SUB_ZFLAG_EN
  assign bus.o_ZERO    = zero;
`endif
endmodule
